// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider. One quotient bit is produced per
//   clock by trial subtraction. The subtraction uses the same two's-complement
//   form as the add/sub ALU: a + ~b + 1. A borrow shows up as a set MSB of the
//   (DATA_BITS+1)-bit trial result. A start/busy/done handshake lets the
//   control unit stall while a DIV completes.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   start        request a division (taken only when not busy)
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse when the result outputs are newly valid
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  set together with done when the divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] dividend,
  input  logic [DATA_BITS-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] quotient,
  output logic [DATA_BITS-1:0] remainder,
  output logic                 div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [DATA_BITS:0] ONE = {{DATA_BITS{1'b0}}, 1'b1};

  logic [1:0]             state;
  logic [DATA_BITS-1:0]   q_reg;
  logic [DATA_BITS-1:0]   d_reg;
  logic [DATA_BITS:0]     r_reg;
  logic [CW-1:0]          count;

  logic [2*DATA_BITS:0]   rq_shift;
  logic [DATA_BITS:0]     r_shift;
  logic [DATA_BITS-1:0]   q_shift;
  logic [DATA_BITS:0]     trial;
  logic                   no_borrow;
  logic [DATA_BITS:0]     r_next;
  logic [DATA_BITS-1:0]   q_next;

  // One restoring iteration: shift {R,Q} left, trial-subtract D from R.
  // A clear trial MSB means no borrow, so the subtraction is kept and a 1
  // enters the quotient; otherwise R is restored (left as shifted).
  always_comb begin
    rq_shift  = {r_reg, q_reg} << 1;
    r_shift   = rq_shift[2*DATA_BITS:DATA_BITS];
    q_shift   = rq_shift[DATA_BITS-1:0];
    trial     = r_shift + ~{1'b0, d_reg} + ONE;
    no_borrow = ~trial[DATA_BITS];
    r_next    = no_borrow ? trial : r_shift;
    q_next    = q_shift | {{(DATA_BITS-1){1'b0}}, no_borrow};
  end

  // Control and datapath registers. FIN behaves like IDLE for accepting a
  // new request, so back-to-back divisions lose no cycle. A zero divisor
  // skips the iteration phase and reports immediately.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= CW'(DATA_BITS);
            if (divisor == '0) begin
              state       <= FIN;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[DATA_BITS-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed testbench for seq_divider with DATA_BITS=8. Each scenario task
//   drives its own stimulus and compares outputs against hand-computed values.
//   Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DATA_BITS(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one clock edge. Returns at the falling edge just
  // after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h5A;
  endtask

  // Waits (bounded) for done. lat counts edges past the current falling edge;
  // busy_cnt counts sampled cycles with busy high before done.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: busy=%b done=%b dbz=%b q=%0d r=%0d, required all 0",
                 i, busy, done, div_by_zero, quotient, remainder);
      end
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    applyStimulus(8'd200, 8'd7);
    wait_done(lat, bc);
    checks++;
    if (lat + 1 != 9) begin
      errors++;
      $display("[TB] FAIL basic_latency: %0d edges, required 9", lat + 1);
    end
    checks++;
    if (bc != 8) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles: %0d, required 8", bc);
    end
    checks++;
    if (busy !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: busy=%b q=%0d r=%0d dbz=%b, required busy=0 q=28 r=4 dbz=0",
               busy, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("[TB] FAIL basic_hold: done=%b q=%0d r=%0d, required done=0 q=28 r=4",
               done, quotient, remainder);
    end
  endtask

  task automatic test_edges;
    logic [W-1:0] a_tab [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd128};
    logic [W-1:0] b_tab [5] = '{8'd1,   8'd9, 8'd3, 8'd255, 8'd2};
    logic [W-1:0] q_tab [5] = '{8'd255, 8'd0, 8'd0, 8'd1,   8'd64};
    logic [W-1:0] r_tab [5] = '{8'd0,   8'd5, 8'd0, 8'd0,   8'd0};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(a_tab[i], b_tab[i]);
      wait_done(lat, bc);
      checks++;
      if (done !== 1'b1 || quotient !== q_tab[i] || remainder !== r_tab[i] || div_by_zero !== 1'b0) begin
        errors++;
        $display("[TB] FAIL edge %0d/%0d: done=%b q=%0d r=%0d dbz=%b, required done=1 q=%0d r=%0d dbz=0",
                 a_tab[i], b_tab[i], done, quotient, remainder, div_by_zero, q_tab[i], r_tab[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    applyStimulus(8'd13, 8'd0);
    wait_done(lat, bc);
    checks++;
    if (lat + 1 != 1 || bc != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dbz_latency: %0d edges busy_cycles=%0d busy=%b, required 1 edge, never busy",
               lat + 1, bc, busy);
    end
    checks++;
    if (quotient !== 8'd255 || remainder !== 8'd13 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_result: q=%0d r=%0d dbz=%b, required q=255 r=13 dbz=1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_pulse: done=%b busy=%b dbz=%b, required done=0 busy=0 dbz=1",
               done, busy, div_by_zero);
    end
    applyStimulus(8'd10, 8'd3);
    wait_done(lat, bc);
    checks++;
    if (quotient !== 8'd3 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dbz_clear: q=%0d r=%0d dbz=%b, required q=3 r=1 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_ignored;
    int lat, bc;
    applyStimulus(8'd100, 8'd10);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat + 3 + 1 != 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored: %0d edges q=%0d r=%0d, required 9 edges q=10 r=0",
               lat + 4, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    applyStimulus(8'd17, 8'd4);
    wait_done(lat, bc);
    checks++;
    if (done !== 1'b1 || quotient !== 8'd4 || remainder !== 8'd1) begin
      errors++;
      $display("[TB] FAIL b2b_first: done=%b q=%0d r=%0d, required done=1 q=4 r=1",
               done, quotient, remainder);
    end
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    @(negedge clk);
    start    = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    wait_done(lat, bc);
    checks++;
    if (lat + 1 != 9 || quotient !== 8'd4 || remainder !== 8'd1) begin
      errors++;
      $display("[TB] FAIL b2b_second: %0d edges q=%0d r=%0d, required 9 edges q=4 r=1",
               lat + 1, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    int seen_done;
    applyStimulus(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear: busy=%b done=%b dbz=%b q=%0d r=%0d, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_abort: %0d active cycles after reset, required 0", seen_done);
    end
    applyStimulus(8'd17, 8'd5);
    wait_done(lat, bc);
    checks++;
    if (quotient !== 8'd3 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_next: q=%0d r=%0d dbz=%b, required q=3 r=2 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  // Scenario sequence; each task leaves the divider idle or in its done cycle.
  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider for the datapath. It sits beside the single-cycle add/sub ALU and performs the inverse arithmetic: repeated trial subtraction, one quotient bit per clock. Subtraction uses the same two's-complement form as the ALU, a + ~b + 1, with the borrow taken from the carry-out. A start/busy/done handshake lets the control unit stall while a DIV instruction completes.

Parameters:
DATA_BITS, 8, operand width of dividend, divisor, quotient and remainder (valid range 2..32)

Ports:
clk  input  1  single clock; all state changes on the rising edge
reset_n  input  1  reset, synchronous, active-low
start  input  1  request a division; sampled only when not busy
dividend  input  DATA_BITS  unsigned dividend; sampled on the accepting edge
divisor  input  DATA_BITS  unsigned divisor; sampled on the accepting edge
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse: quotient, remainder and div_by_zero are newly valid
quotient  output  DATA_BITS  registered quotient; held until the next completion
remainder  output  DATA_BITS  registered remainder; held until the next completion
div_by_zero  output  1  set with done when divisor was 0; held until the next completion

Behaviour:
- Reset: on a rising edge with reset_n=0:
  - state goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal shift registers and the counter are cleared.
  - A reset mid-division aborts it; no done pulse is produced.
- States:
  - IDLE: not busy.
  - RUN: iterating.
  - FIN: 1-cycle done pulse. FIN accepts start exactly like IDLE.
- Accept: the edge E0 where start=1 and state is IDLE or FIN.
  - Latch dividend into the working quotient register Q.
  - Latch divisor into D.
  - Clear the partial remainder R, which is DATA_BITS+1 bits.
  - Set count=DATA_BITS.
- Divide-by-zero: if divisor==0 at E0, no RUN phase.
  - At E0: state goes to FIN, quotient set to all ones, remainder set to dividend, div_by_zero=1, done=1.
  - Latency is 1 edge.
- Normal path: at E0, state goes to RUN, busy=1, div_by_zero=0.
- Each RUN edge performs one iteration:
  - {R,Q} is shifted left 1.
  - trial = R + ~{1'b0,D} + 1, computed at DATA_BITS+1 bits.
  - If trial MSB==0 (no borrow): R=trial and Q LSB=1.
  - Otherwise R is unchanged and Q LSB=0.
  - count decrements by 1.
- Finish: the edge E_N where count reaches 0, which is E0+DATA_BITS.
  - quotient=Q(final) and remainder=R[DATA_BITS-1:0].
  - done=1, busy=0, state goes to FIN.
  - Latency: done is high in the cycle after E_N, which is DATA_BITS+1 edges after start is sampled.
- done is high for exactly one cycle.
  - FIN goes to IDLE unless start is accepted.
  - If start is accepted in FIN, the new division begins at that edge, and done still drops after 1 cycle.
- start while busy=1 is ignored; inputs are not resampled and no error is flagged.
- dividend and divisor may change freely after E0 without affecting the result in progress.
- Result invariant for divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.
- quotient, remainder and div_by_zero are not changed during RUN; they show the previous result.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 edges, release, hold start=0 for 10 edges -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 throughout.
- Basic divide (DATA_BITS=8): start with 200/7 -> busy=1 for 8 cycles; done for 1 cycle, 9 edges after the accepting edge; quotient=28, remainder=4, div_by_zero=0; outputs held afterwards.
- Edge values:
  - 255/1 -> q=255, r=0.
  - 5/9 -> q=0, r=5.
  - 0/3 -> q=0, r=0.
  - 255/255 -> q=1, r=0.
  - 128/2 -> q=64, r=0.
- Divide-by-zero: start with 13/0 -> done 1 edge after accept; quotient=255, remainder=13, div_by_zero=1; busy never high. A following 10/3 clears div_by_zero: q=3, r=1.
- Handshake:
  - start 100/10, then pulse start with 50/5 at RUN cycle 3 -> ignored; result q=10, r=0.
  - Assert start=1 with 9/2 during the done cycle -> accepted; next result q=4, r=1.
- Reset mid-operation: start 200/7, drop reset_n at RUN cycle 4 for 1 edge -> no done pulse; all outputs 0; a subsequent 17/5 gives q=3, r=2.
